// File: rtl/pc_seq.sv
// Program counter sequencer: increment, absolute/relative branch, and call/return
// through a small LIFO return-address stack with sticky overflow/underflow flags.
module pc_seq #(
  parameter int Psize  = 6,
  parameter int Sdepth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     PCincr,
  input  logic                     PCabsbranch,
  input  logic                     PCrelbranch,
  input  logic                     call,
  input  logic                     ret,
  input  logic [Psize-1:0]         Branchaddr,
  output logic [Psize-1:0]         PCout,
  output logic [$clog2(Sdepth):0]  depth,
  output logic                     stack_ovf,
  output logic                     stack_unf
);

  localparam int AW = $clog2(Sdepth);
  localparam int DW = AW + 1;

  logic [Psize-1:0] r_pc_reg, r_pc_next;
  logic [DW-1:0]    r_depth_reg, r_depth_next;
  logic             r_ovf_reg, r_ovf_next;
  logic             r_unf_reg, r_unf_next;
  logic [Psize-1:0] r_stack [Sdepth];

  logic [Psize-1:0] w_pc_inc;
  logic [Psize-1:0] w_pc_rel;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic [Psize-1:0] w_top;
  logic             w_push;

  // Same-width add: sign extension of the offset to Psize bits is the identity.
  assign w_pc_inc   = r_pc_reg + Psize'(1);
  assign w_pc_rel   = r_pc_reg + Branchaddr;
  assign w_full     = (r_depth_reg == DW'(Sdepth));
  assign w_empty    = (r_depth_reg == '0);
  assign w_top_idx  = AW'(r_depth_reg - DW'(1));
  assign w_push_idx = r_depth_reg[AW-1:0];
  assign w_top      = r_stack[w_top_idx];
  assign w_push     = en && !reset && !ret && call && !w_full;

  always_comb begin
    r_pc_next    = r_pc_reg;
    r_depth_next = r_depth_reg;
    r_ovf_next   = r_ovf_reg;
    r_unf_next   = r_unf_reg;
    if (en) begin
      if (ret) begin
        if (w_empty) begin
          r_unf_next = 1'b1;
          r_pc_next  = w_pc_inc;
        end else begin
          r_pc_next    = w_top;
          r_depth_next = r_depth_reg - DW'(1);
        end
      end else if (call) begin
        r_pc_next = Branchaddr;
        if (w_full) begin
          r_ovf_next = 1'b1;
        end else begin
          r_depth_next = r_depth_reg + DW'(1);
        end
      end else if (PCabsbranch) begin
        r_pc_next = Branchaddr;
      end else if (PCrelbranch) begin
        r_pc_next = w_pc_rel;
      end else if (PCincr) begin
        r_pc_next = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_reg    <= '0;
      r_depth_reg <= '0;
      r_ovf_reg   <= 1'b0;
      r_unf_reg   <= 1'b0;
    end else begin
      r_pc_reg    <= r_pc_next;
      r_depth_reg <= r_depth_next;
      r_ovf_reg   <= r_ovf_next;
      r_unf_reg   <= r_unf_next;
    end
  end

  // Stack storage needs no reset: entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign PCout     = r_pc_reg;
  assign depth     = r_depth_reg;
  assign stack_ovf = r_ovf_reg;
  assign stack_unf = r_unf_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Directed testbench for pc_seq (Psize=6, Sdepth=4) with hand-computed expectations.
module tb_pc_seq;

  logic       clk;
  logic       reset;
  logic       en;
  logic       PCincr;
  logic       PCabsbranch;
  logic       PCrelbranch;
  logic       call;
  logic       ret;
  logic [5:0] Branchaddr;
  logic [5:0] PCout;
  logic [2:0] depth;
  logic       stack_ovf;
  logic       stack_unf;

  int n_checks;
  int n_errors;

  pc_seq #(.Psize(6), .Sdepth(4)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .PCincr(PCincr),
    .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch),
    .call(call),
    .ret(ret),
    .Branchaddr(Branchaddr),
    .PCout(PCout),
    .depth(depth),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across a single rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic inc, input logic ab,
                      input logic rl, input logic c, input logic rt, input logic [5:0] ba);
    reset = r; en = e; PCincr = inc; PCabsbranch = ab; PCrelbranch = rl;
    call = c; ret = rt; Branchaddr = ba;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b en=%0b inc=%0b abs=%0b rel=%0b call=%0b ret=%0b ba=%0d -> PC=%0d depth=%0d ovf=%0b unf=%0b",
             $time, r, e, inc, ab, rl, c, rt, ba, PCout, depth, stack_ovf, stack_unf);
  endtask

  task automatic check_state(input string tag, input int pc, input int dp, input int ovf, input int unf);
    check({tag, "_pc"}, 32'(PCout), 32'(pc));
    check({tag, "_depth"}, 32'(depth), 32'(dp));
    check({tag, "_ovf"}, 32'(stack_ovf), 32'(ovf));
    check({tag, "_unf"}, 32'(stack_unf), 32'(unf));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; en = 1'b0; PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0;
    call = 1'b0; ret = 1'b0; Branchaddr = '0;

    // Reset, with en and requests asserted to prove override
    step(1, 1, 1, 0, 0, 0, 0, 6'd0);
    step(1, 1, 1, 1, 0, 1, 0, 6'd17);
    check_state("reset", 0, 0, 0, 0);

    // Increment wrap; first edge after reset acts immediately
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 1, 0, 0, 0, 0, 6'd0);
      check("incr_wrap", 32'(PCout), 32'((i + 1) % 64));
    end

    // Relative branches
    step(0, 1, 0, 1, 0, 0, 0, 6'd10);
    check("abs_10", 32'(PCout), 32'd10);
    step(0, 1, 0, 0, 1, 0, 0, 6'h3E);
    check("rel_minus2", 32'(PCout), 32'd8);
    step(0, 1, 0, 1, 0, 0, 0, 6'd62);
    step(0, 1, 0, 0, 1, 0, 0, 6'd5);
    check("rel_wrap", 32'(PCout), 32'd3);
    step(0, 1, 0, 0, 1, 0, 0, 6'h3F);
    check("rel_minus1", 32'(PCout), 32'd2);

    // Nested call/return
    step(0, 1, 0, 1, 0, 0, 0, 6'd5);
    step(0, 1, 0, 0, 0, 1, 0, 6'd20);
    check_state("call1", 20, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 6'd40);
    check_state("call2", 40, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("ret1", 21, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("ret2", 6, 0, 0, 0);

    // Overflow: PC=6 pushes 7, then 11, 12, 13; fifth call not pushed
    step(0, 1, 0, 0, 0, 1, 0, 6'd10);
    step(0, 1, 0, 0, 0, 1, 0, 6'd11);
    step(0, 1, 0, 0, 0, 1, 0, 6'd12);
    step(0, 1, 0, 0, 0, 1, 0, 6'd13);
    check_state("call4", 13, 4, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 6'd14);
    check_state("call5_ovf", 14, 4, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("drain1", 13, 3, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("drain2", 12, 2, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("drain3", 11, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("drain4", 7, 0, 1, 0);
    // Underflow at depth 0 from PC=7
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("ret_unf", 8, 0, 1, 1);

    // Priority and hold
    step(0, 1, 0, 0, 0, 1, 0, 6'd30);
    check_state("call30", 30, 1, 1, 1);
    step(0, 1, 1, 0, 0, 1, 1, 6'd50);
    check_state("call_ret_incr", 9, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0, 6'd33);
    check_state("en0_abs", 9, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 6'd33);
    check_state("en0_call", 9, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0, 6'd33);
    check("idle_hold", 32'(PCout), 32'd9);
    step(0, 1, 1, 1, 1, 0, 0, 6'd2);
    check("abs_over_rel", 32'(PCout), 32'd2);
    step(0, 1, 1, 0, 1, 0, 0, 6'd4);
    check("rel_over_incr", 32'(PCout), 32'd6);

    // Reset mid-operation at depth 3 with flags set
    step(0, 1, 0, 0, 0, 1, 0, 6'd40);
    step(0, 1, 0, 0, 0, 1, 0, 6'd41);
    step(0, 1, 0, 0, 0, 1, 0, 6'd42);
    check_state("pre_reset", 42, 3, 1, 1);
    step(1, 1, 0, 0, 0, 1, 0, 6'd43);
    check_state("mid_reset", 0, 0, 0, 0);
    // Stack discarded: ret after reset underflows
    step(0, 1, 0, 0, 0, 0, 1, 6'd0);
    check_state("post_reset_ret", 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter Psize, default 6, meaning PC/program-memory address width.
REQ-002 SHALL have parameter Sdepth, default 4, meaning return-address stack depth (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  advance enable; 0 = hold all state.
REQ-006 SHALL have port PCincr  input  1  sequential increment request.
REQ-007 SHALL have port PCabsbranch  input  1  absolute jump to Branchaddr.
REQ-008 SHALL have port PCrelbranch  input  1  relative jump by signed Branchaddr.
REQ-009 SHALL have port call  input  1  push return address, jump to Branchaddr.
REQ-010 SHALL have port ret  input  1  pop return address into PC.
REQ-011 SHALL have port Branchaddr  input  Psize  target (absolute) or two's-complement offset (relative).
REQ-012 SHALL have port PCout  output  Psize  registered PC, driven directly to program-memory address.
REQ-013 SHALL have port depth  output  $clog2(Sdepth)+1  current stack occupancy.
REQ-014 SHALL have port stack_ovf  output  1  sticky overflow flag.
REQ-015 SHALL have port stack_unf  output  1  sticky underflow flag.

Function
REQ-016 SHALL register PCout; a request sampled at edge N is visible on PCout after edge N (one-cycle latency, no combinational input-to-PCout path).
REQ-017 SHALL, when en=0, hold PCout, stack, depth and flags regardless of other inputs.
REQ-018 SHALL, when en=1, apply exactly one action per cycle, priority: ret > call > PCabsbranch > PCrelbranch > PCincr > hold.
REQ-019 SHALL on PCincr set PC = PC+1 modulo 2^Psize (max value wraps to 0).
REQ-020 SHALL on PCrelbranch set PC = PC + sign-extended Branchaddr modulo 2^Psize (Branchaddr all-ones = PC-1).
REQ-021 SHALL on PCabsbranch set PC = Branchaddr.
REQ-022 SHALL on call with depth<Sdepth push (PC+1) mod 2^Psize, increment depth, set PC = Branchaddr.
REQ-023 SHALL on call with depth==Sdepth not push, leave stack/depth unchanged, set stack_ovf=1, still set PC = Branchaddr.
REQ-024 SHALL on ret with depth>0 set PC = top entry, decrement depth.
REQ-025 SHALL on ret with depth==0 set stack_unf=1, leave depth at 0, set PC = PC+1 mod 2^Psize.
REQ-026 SHALL treat call and ret asserted together as ret only (call ignored, no push).
REQ-027 SHALL implement the stack as LIFO; entries above depth are don't-care and never observable.
REQ-028 SHALL keep stack_ovf/stack_unf set once set, until reset.
REQ-029 SHALL hold PC when en=1 and no request is asserted.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set PCout=0, depth=0, stack_ovf=0, stack_unf=0, overriding en and all requests.
REQ-031 SHALL discard any stack contents on reset; reset mid-call/ret sequence leaves empty stack.
REQ-032 SHALL, on the first edge after reset deasserts, act on requests normally (no dead cycle).

Verification
REQ-033 SHALL verify increment wrap: reset, PCincr=1 for 64 cycles (Psize=6) -> PCout 0,1,...,63,0.
REQ-034 SHALL verify relative branch: PC=10, PCrelbranch, Branchaddr=6'h3E -> PCout=8; PC=62, Branchaddr=5 -> PCout=3.
REQ-035 SHALL verify nesting: PC=5 call 20; PC=20 call 40; ret -> PCout=21, depth=1; ret -> PCout=6, depth=0.
REQ-036 SHALL verify overflow/underflow: 5 calls with Sdepth=4 -> depth=4, stack_ovf=1, PCout=last target; ret at depth 0 from PC=7 -> PCout=8, stack_unf=1.
REQ-037 SHALL verify priority/hold: call+ret+PCincr together -> ret only; en=0 with PCabsbranch -> PCout unchanged.
REQ-038 SHALL verify reset mid-operation: depth=3, flags set, reset=1 with call asserted -> PCout=0, depth=0, flags 0 next cycle.
